load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Sits between riscv_core's load/store path and the byte-lane data memory (mem_addr, mem_data_out[0:3],
//  mem_data_in[0:3], mem_write_en). Executes LB/LH/LW/LBU/LHU/SB/SH/SW.
//  Partial stores use read-modify-write on word-aligned memory. Misaligned accesses that span two words
//  are split into two word accesses. One response is returned per request via a valid/ready handshake.
// PARAMETERS
//  ALLOW_MISALIGNED  1  1: split word-spanning accesses; 0: flag them with resp_err, no memory access
// PORTS
//  clk           in   1      clock; all state updates on posedge
//  rst_b         in   1      synchronous active-low reset
//  req_valid     in   1      request present
//  req_ready     out  1      block can accept; high only in IDLE
//  req_store     in   1      1=store, 0=load
//  req_funct3    in   3      RV32I funct3 (load 0,1,2,4,5; store 0,1,2)
//  req_addr      in   32     byte address
//  req_wdata     in   32     store data (low bytes used for SB/SH)
//  resp_valid    out  1      one-cycle pulse: request complete
//  resp_err      out  1      valid with resp_valid: illegal funct3, or span with ALLOW_MISALIGNED=0
//  resp_rdata    out  32     load result, extended; 0 for stores/errors; held until next resp_valid
//  mem_addr      out  32     word-aligned memory address
//  mem_data_out  in   8x4    memory read bytes, combinational; lane i = byte at mem_addr+i
//  mem_data_in   out  8x4    memory write bytes
//  mem_write_en  out  1      write mem_data_in at mem_addr on this posedge
// BEHAVIOUR
//  Reset: rst_b=0 at a posedge -> state IDLE, resp_valid=0, resp_err=0, resp_rdata=0.
//   While in IDLE: mem_write_en=0, mem_addr=0, mem_data_in=0.
//   req_ready is forced to 0 while rst_b=0.
//  Handshake: accept on posedge with req_valid&&req_ready. Latch store, funct3, addr and wdata.
//   Inputs are ignored in all other states.
//  Decode: base=addr&~3, off=addr[1:0], size=1/2/4 from funct3[1:0].
//   span = off+size>4. base1 = base+4, mod 2^32 (0xFFFFFFFC wraps to 0).
//  Little-endian: byte k of the access is at address addr+k.
//   LB/LH sign-extend; LBU/LHU zero-extend.
//  FSM states: IDLE, RD0, RD1, WR0, WR1, RESP.
//   IDLE -> RESP with resp_err=1 on illegal funct3, or on span with ALLOW_MISALIGNED=0.
//   Load:           IDLE -> RD0 -> (span ? RD1 :) -> RESP.
//   Aligned SW:     IDLE -> WR0 -> RESP (no read).
//   Partial/misaligned store: IDLE -> RD0 -> WR0 -> (span ? RD1 -> WR1 :) -> RESP.
//   RESP -> IDLE unconditionally.
//  RDn: mem_addr=base(n); mem_data_out sampled into a word buffer at the posedge ending the state.
//  WRn: mem_addr=base(n); mem_write_en=1.
//   Buffered bytes are driven on mem_data_in, with addressed lanes replaced by store bytes.
//   Unaddressed lanes are written back unchanged.
//  RESP: resp_valid=1 for exactly one cycle; resp_rdata/resp_err updated at entry to RESP.
//  Latency, accept edge=T, resp_valid high in cycle after edge:
//   aligned load / SW: T+2; span load: T+3; partial store: T+3; span store: T+5.
//   Error: T+1.
//  Throughput: the next request is accepted no earlier than the cycle after RESP.
//  Reset mid-operation: abandon at the reset edge and emit no response.
//   A write already committed at an earlier edge stands; no later WR state occurs.
// TESTING
//  mem[0x100..0x103]=11 22 33 84; LW 0x100 -> rdata=0x84332211 at T+2, no writes.
//  Same mem; LB 0x103 -> 0xFFFFFF84; LBU 0x103 -> 0x00000084; LH 0x102 -> 0xFFFF8433.
//  SH 0x101 wdata=0xAABB -> one write to 0x100 with bytes 11 BB AA 84, resp at T+3.
//  mem[0x104..]=55 66 77 88; LW 0x102 -> 0x66558433 at T+3.
//   SW 0x103 0xDEADBEEF -> 0x100=11 22 33 EF, 0x104=BE AD DE 88.
//  LW 0xFFFFFFFE -> reads 0xFFFFFFFC then 0x00000000.
//   ALLOW_MISALIGNED=0 -> resp_err=1 at T+1, no mem access.
//   Load funct3=3 -> resp_err=1, rdata=0.
//  Span store with rst_b=0 during RD1 -> no WR1 write, no resp_valid.
//   Next edge: IDLE, req_ready=1 once rst_b=1.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bundles the core-side request/response handshake and the byte-lane data memory bus
// of the load/store unit. slave is the unit's view; master is the core-plus-memory view.
interface load_store_unit_if;
  logic             req_valid;
  logic             req_ready;
  logic             req_store;
  logic [2:0]       req_funct3;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic             resp_valid;
  logic             resp_err;
  logic [31:0]      resp_rdata;
  logic [31:0]      mem_addr;
  logic [3:0][7:0]  mem_data_out;
  logic [3:0][7:0]  mem_data_in;
  logic             mem_write_en;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_data_out,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_data_in, mem_write_en
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_data_out,
    input  req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_data_in, mem_write_en
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte/half/word accesses on a word-organised byte-lane memory,
// with read-modify-write for partial stores and two-word splitting of spanning accesses.
module load_store_unit #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input logic              clk,
  input logic              rst_b,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_t;

  state_t          state;
  state_t          state_next;

  logic            store;
  logic [2:0]      funct3;
  logic [31:0]     addr;
  logic [3:0][7:0] wdata;
  logic [3:0][7:0] buf0;
  logic [3:0][7:0] buf1;
  logic            resp_err_q;
  logic [31:0]     resp_rdata_q;

  logic            dec_store;
  logic [2:0]      dec_funct3;
  logic [31:0]     dec_addr;
  logic [1:0]      dec_off;
  logic [2:0]      dec_size;
  logic [3:0]      dec_end;
  logic            dec_span;
  logic            dec_illegal;
  logic            dec_err;
  logic            dec_full_word;
  logic [31:0]     base0;
  logic [31:0]     base1;

  logic [3:0][7:0] buf0_next;
  logic [3:0][7:0] buf1_next;
  logic [7:0][7:0] window;
  logic [2:0]      win_idx;
  logic [3:0][7:0] ld_bytes;
  logic            ld_ext;
  logic [31:0]     load_result;

  logic            wr_hi;
  logic [3:0][7:0] merged;
  logic [3:0]      lane_pos;
  logic [1:0]      lane_rel;

  // In IDLE the decode looks at the live request so the accept edge can already branch
  always_comb begin
    dec_store  = store;
    dec_funct3 = funct3;
    dec_addr   = addr;
    if (state == IDLE) begin
      dec_store  = bus.req_store;
      dec_funct3 = bus.req_funct3;
      dec_addr   = bus.req_addr;
    end
    dec_off = dec_addr[1:0];
    case (dec_funct3[1:0])
      2'b00:   dec_size = 3'd1;
      2'b01:   dec_size = 3'd2;
      default: dec_size = 3'd4;
    endcase
    dec_end  = {2'b00, dec_off} + {1'b0, dec_size};
    dec_span = dec_end > 4'd4;
    if (dec_store) begin
      dec_illegal = dec_funct3[2] || (dec_funct3[1:0] == 2'b11);
    end else begin
      dec_illegal = (dec_funct3[1:0] == 2'b11) || (dec_funct3 == 3'b110);
    end
    dec_err       = dec_illegal || (dec_span && !ALLOW_MISALIGNED);
    dec_full_word = (dec_size == 3'd4) && (dec_off == 2'b00);
    base0         = {dec_addr[31:2], 2'b00};
    base1         = base0 + 32'd4;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (dec_err)                       state_next = RESP;
          else if (dec_store && dec_full_word) state_next = WR0;
          else                               state_next = RD0;
        end
      end
      RD0:     state_next = dec_store ? WR0 : (dec_span ? RD1 : RESP);
      WR0:     state_next = dec_span ? RD1 : RESP;
      RD1:     state_next = dec_store ? WR1 : RESP;
      WR1:     state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The load result is formed at the edge that enters RESP, so the word being read
  // in that same cycle is taken straight from the memory bus.
  always_comb begin
    buf0_next = (state == RD0) ? bus.mem_data_out : buf0;
    buf1_next = (state == RD1) ? bus.mem_data_out : buf1;
    window    = {buf1_next, buf0_next};
    win_idx   = '0;
    ld_bytes  = '0;
    for (int k = 0; k < 4; k++) begin
      win_idx     = {1'b0, dec_off} + 3'(k);
      ld_bytes[k] = window[win_idx];
    end
    case (dec_funct3[1:0])
      2'b00: begin
        ld_ext      = ~dec_funct3[2] & ld_bytes[0][7];
        load_result = {{24{ld_ext}}, ld_bytes[0]};
      end
      2'b01: begin
        ld_ext      = ~dec_funct3[2] & ld_bytes[1][7];
        load_result = {{16{ld_ext}}, ld_bytes[1], ld_bytes[0]};
      end
      default: begin
        ld_ext      = 1'b0;
        load_result = ld_bytes;
      end
    endcase
  end

  // Lane positions count across both words (0..7) so one comparison against the
  // access window covers the first and second write alike.
  always_comb begin
    wr_hi    = (state == WR1);
    merged   = wr_hi ? buf1 : buf0;
    lane_pos = '0;
    lane_rel = '0;
    for (int i = 0; i < 4; i++) begin
      lane_pos = 4'(i) + (wr_hi ? 4'd4 : 4'd0);
      lane_rel = 2'(i) - dec_off;
      if ((lane_pos >= {2'b00, dec_off}) && (lane_pos < dec_end)) begin
        merged[i] = wdata[lane_rel];
      end
    end
  end

  always_comb begin
    bus.req_ready    = rst_b && (state == IDLE);
    bus.resp_valid   = (state == RESP);
    bus.resp_err     = resp_err_q;
    bus.resp_rdata   = resp_rdata_q;
    bus.mem_addr     = '0;
    bus.mem_data_in  = '0;
    bus.mem_write_en = 1'b0;
    case (state)
      RD0: bus.mem_addr = base0;
      RD1: bus.mem_addr = base1;
      WR0: begin
        bus.mem_addr     = base0;
        bus.mem_data_in  = merged;
        bus.mem_write_en = rst_b;
      end
      WR1: begin
        bus.mem_addr     = base1;
        bus.mem_data_in  = merged;
        bus.mem_write_en = rst_b;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state        <= IDLE;
      store        <= 1'b0;
      funct3       <= '0;
      addr         <= '0;
      wdata        <= '0;
      buf0         <= '0;
      buf1         <= '0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state <= state_next;
      buf0  <= buf0_next;
      buf1  <= buf1_next;
      if ((state == IDLE) && bus.req_valid) begin
        store  <= bus.req_store;
        funct3 <= bus.req_funct3;
        addr   <= bus.req_addr;
        wdata  <= bus.req_wdata;
      end
      // Only errors go straight from IDLE to RESP
      if ((state_next == RESP) && (state != RESP)) begin
        resp_err_q   <= (state == IDLE);
        resp_rdata_q <= ((state == IDLE) || dec_store) ? 32'd0 : load_result;
      end
    end
  end

endmodule
